// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select constants used by the core decoder and the
// multiplier sequencer, plus the sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_SUB = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_NOR = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu32.sv
// Shared single-cycle 32-bit ALU. Purely combinational; shift amount is b[4:0].
module alu32
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] r
);

    // Select the result of the requested operation.
    always_comb begin
        r = 32'd0;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_XOR: r = a ^ b;
            ALU_SUB: r = a - b;
            ALU_SRL: r = a >> b[4:0];
            ALU_SLL: r = a << b[4:0];
            ALU_NOR: r = ~(a | b);
            default: r = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_mult_seq.sv
// Shift-add multiplier sequencer. Borrows the shared ALU while busy to form the
// low word of a*b: one ADD per set multiplier bit, one SLL of the multiplicand
// per multiplier bit up to the most significant set bit.
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r
);

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] product_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] mplier_shr_s;
    logic             shift_last_s;

    // Multiplier after this SHIFT step and whether that step is the final one.
    always_comb begin
        mplier_shr_s = mplier_r >> 1;
        if ((mplier_shr_s == {WIDTH{1'b0}}) || (cnt_r == CNT_W'(WIDTH - 1))) begin
            shift_last_s = 1'b1;
        end else begin
            shift_last_s = 1'b0;
        end
    end

    // Status and ALU operand drive, decoded from the current state.
    always_comb begin
        busy   = 1'b1;
        done   = 1'b0;
        alu_op = ALU_AND;
        alu_a  = {WIDTH{1'b0}};
        alu_b  = {WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            ADD: begin
                alu_op = ALU_ADD;
                alu_a  = acc_r;
                alu_b  = mcand_r;
            end
            SHIFT: begin
                alu_op = ALU_SLL;
                alu_a  = mcand_r;
                alu_b  = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Sequencer state and datapath registers. The product is captured on the
    // edge that enters DONE so it is already valid while done is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            acc_r     <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            product_r <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= a_in;
                        mplier_r <= b_in;
                        acc_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        if (b_in == {WIDTH{1'b0}}) begin
                            product_r <= {WIDTH{1'b0}};
                            state_r   <= DONE;
                        end else if (b_in[0]) begin
                            state_r <= ADD;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    acc_r   <= alu_r;
                    state_r <= SHIFT;
                end
                SHIFT: begin
                    mcand_r  <= alu_r;
                    mplier_r <= mplier_shr_s;
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (shift_last_s) begin
                        product_r <= acc_r;
                        state_r   <= DONE;
                    end else if (mplier_r[1]) begin
                        state_r <= ADD;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign product = product_r;

endmodule
